mult_scheduler: RTL and testbench
=================================

// Module: mult_scheduler
// PURPOSE
//  Shares one instance of the team's registered multiplier (`multiplicador`, TAM-bit operands)
//  between NREQ requesters using round-robin arbitration and valid/ready handshakes.
//  Sits between the requesting blocks and the multiplier. Returns each product with the
//  requester's ID. Strictly one transaction in flight.
// PARAMETERS
//  TAM   8  operand width in bits; product width is 2*TAM
//  NREQ  4  number of requesters (2..8)
//  IDW   2  requester ID width, = clog2(NREQ)
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          synchronous reset, active-high
//  req_valid  in   NREQ       per-requester operand valid
//  req_a      in   NREQ*TAM   packed operand A; requester i uses [i*TAM +: TAM]
//  req_b      in   NREQ*TAM   packed operand B; same packing as req_a
//  req_ready  out  NREQ       per-requester accept strobe; one-hot or zero
//  resp_valid out  1          product valid
//  resp_ready in   1          consumer accepts the product
//  resp_s     out  2*TAM      unsigned product A*B; 0 when resp_valid=0
//  resp_id    out  IDW        index of the requester that owns resp_s
//  busy       out  1          1 whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, rr_ptr=NREQ-1 (requester 0 wins first), req_ready=0,
//   resp_valid=0, resp_id=0, busy=0, resp_s=0, operand registers=0.
//  FSM states:
//   IDLE: if |req_valid, grant g = first valid requester after rr_ptr, searching cyclically.
//     req_ready[g]=1 combinationally in this cycle.
//     At the clock edge: latch req_a/req_b of g into operand registers, resp_id<=g, go to CALC.
//     If no request is valid, stay in IDLE.
//   CALC: operand registers drive the multiplier; the multiplier registers S at this edge.
//     Go to RESP unconditionally.
//   RESP: resp_valid=1, resp_s=multiplier S.
//     Operand registers are frozen, so resp_s stays stable while held.
//     On resp_valid&&resp_ready: rr_ptr<=resp_id, go to IDLE.
//     Otherwise hold every output.
//  Latency: accept edge at cycle t -> resp_valid high in cycle t+2.
//   Peak throughput is one product per 3 cycles.
//  req_ready is asserted only in IDLE. A requester must hold valid and data until it sees ready.
//   If req_valid drops before grant, the request is simply not seen.
//  Requests arriving in CALC or RESP are ignored; they compete at the next IDLE.
//  Simultaneous requests: round-robin only; no fixed priority beyond rr_ptr.
//  Arithmetic: unsigned TAM x TAM -> 2*TAM; never overflows, no truncation.
//  rst mid-transaction (CALC or RESP): the transaction is dropped and no response is produced.
//   All reset values take effect at the next edge.
// CONFIGURATION
//  Macro MULT_SCHED_STATS_EN:
//   defined: adds output port grant_cnt (NREQ*16 bits); requester i uses [i*16 +: 16].
//     Each field is a 16-bit counter. It increments on every accepted request
//     (req_valid[i]&&req_ready[i]) and saturates at 16'hFFFF. rst clears it to 0.
//   undefined: no port, no counters; all other behaviour identical.
// STRUCTURE
//  Shared include mult_sched_defs.vh holds:
//   state encodings S_IDLE=2'd0, S_CALC=2'd1, S_RESP=2'd2;
//   counter width CNT_W=16; default TAM and NREQ.
//  Sub-module rr_arbiter: inputs req[NREQ] and ptr[IDW]; outputs gnt[NREQ] (one-hot) and gnt_id.
//   It is purely combinational.
//  Datapath: one instance of `multiplicador` #(.TAM(TAM)).
// TESTING
//  1. Hold rst=1 for 2 cycles with all req_valid=1 -> req_ready=0, resp_valid=0, busy=0, resp_s=0.
//  2. req_valid=4'b0100, A2=12, B2=13, resp_ready=1 -> req_ready=4'b0100 in cycle 0;
//     resp_valid=1, resp_s=156, resp_id=2 in cycle 2.
//  3. req_valid=4'b1111 held, resp_ready=1 -> grants 0,1,2,3,0 at 3-cycle spacing.
//  4. A=B=255 -> resp_s=16'hFE01 (65025).
//  5. Hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_s and resp_id stay stable;
//     req_ready=0 throughout. Raising resp_ready returns the FSM to IDLE at the next edge.
//  6. Assert rst during CALC -> no resp_valid follows, and the next grant goes to requester 0.
//     With MULT_SCHED_STATS_EN: after test 3 runs 8 grants, grant_cnt fields = 2,2,2,2;
//     after rst all fields = 0.

Source files
------------

// File: rtl/mult_scheduler_pkg.sv
// Shared constants for the multiplier scheduler: FSM encodings, counter width, defaults.
package mult_scheduler_pkg;

    localparam int DEF_TAM  = 8;
    localparam int DEF_NREQ = 4;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mult_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, cyclically.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id
);

    logic           w_found;
    logic [IDW-1:0] w_idx;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        w_idx   = '0;
        // Offset 1 first, so ptr itself has the lowest priority this round.
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IDW'((int'(ptr) + k) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found    = 1'b1;
                gnt[w_idx] = 1'b1;
                gnt_id     = w_idx;
            end
        end
    end

endmodule

// File: rtl/multiplicador.sv
// Registered unsigned TAM x TAM multiplier; S updates on every rising edge.
module multiplicador #(
    parameter int TAM = 8
) (
    input  logic               clk,
    input  logic [TAM-1:0]     A,
    input  logic [TAM-1:0]     B,
    output logic [2*TAM-1:0]   S
);

    always_ff @(posedge clk) begin
        S <= A * B;
    end

endmodule

// File: rtl/mult_scheduler.sv
// Round-robin scheduler sharing one registered multiplier among NREQ requesters.
// Optional per-requester grant counters are enabled with the MULT_SCHED_STATS_EN macro.
module mult_scheduler
    import mult_scheduler_pkg::*;
#(
    parameter int TAM  = DEF_TAM,
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*TAM-1:0]   req_a,
    input  logic [NREQ*TAM-1:0]   req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [2*TAM-1:0]      resp_s,
    output logic [IDW-1:0]        resp_id,
    output logic                  busy,
`ifdef MULT_SCHED_STATS_EN
    output logic [NREQ*CNT_W-1:0] grant_cnt,
`endif
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
    // Requesters hold valid and data until ready; the consumer sees resp_s held until accepted.

    state_t             r_state;
    logic [IDW-1:0]     r_rr_ptr;
    logic [TAM-1:0]     r_op_a;
    logic [TAM-1:0]     r_op_b;
    logic [IDW-1:0]     r_resp_id;

    logic [NREQ-1:0]    w_gnt;
    logic [IDW-1:0]     w_gnt_id;
    logic [2*TAM-1:0]   w_s;
    logic               w_idle;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req    (req_valid),
        .ptr    (r_rr_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    multiplicador #(.TAM(TAM)) u_mult (
        .clk (clk),
        .A   (r_op_a),
        .B   (r_op_b),
        .S   (w_s)
    );

    assign w_idle     = (r_state == S_IDLE);
    // Suppressed during reset so no requester believes it was accepted.
    assign req_ready  = (w_idle && !rst) ? w_gnt : '0;
    assign resp_valid = (r_state == S_RESP);
    assign resp_s     = resp_valid ? w_s : '0;
    assign resp_id    = r_resp_id;
    assign busy       = !w_idle;
    assign dbg_state  = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= IDW'(NREQ - 1);
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_resp_id <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req_valid) begin
                        r_op_a    <= req_a[w_gnt_id*TAM +: TAM];
                        r_op_b    <= req_b[w_gnt_id*TAM +: TAM];
                        r_resp_id <= w_gnt_id;
                        r_state   <= S_CALC;
                    end
                end
                S_CALC: r_state <= S_RESP;
                S_RESP: begin
                    if (resp_ready) begin
                        r_rr_ptr <= r_resp_id;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MULT_SCHED_STATS_EN
    logic [CNT_W-1:0] r_cnt [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt[i] <= '0;
            end else if (req_valid[i] && req_ready[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = r_cnt[i];
    end
`endif

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler; build with MULT_SCHED_STATS_EN to cover the grant counters.
module tb_mult_scheduler;

  localparam int TAM  = 8;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*TAM-1:0] req_a = '0;
  logic [NREQ*TAM-1:0] req_b = '0;
  logic [NREQ-1:0]     req_ready;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [2*TAM-1:0]    resp_s;
  logic [IDW-1:0]      resp_id;
  logic                busy;
  logic [1:0]          dbg_state;
`ifdef MULT_SCHED_STATS_EN
  logic [NREQ*16-1:0]  grant_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*TAM-1:0] exp_q[$];
  logic [2*TAM-1:0] exp_s;

  mult_scheduler #(.TAM(TAM), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_s     (resp_s),
    .resp_id    (resp_id),
    .busy       (busy),
`ifdef MULT_SCHED_STATS_EN
    .grant_cnt  (grant_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [TAM-1:0] a, input logic [TAM-1:0] b);
    req_a[i*TAM +: TAM] = a;
    req_b[i*TAM +: TAM] = b;
  endtask

  initial begin
    // T1: reset held two cycles with all requesters valid
    rst = 1'b1;
    req_valid = 4'b1111;
    step();
    step();
    check("t1_ready", 32'(req_ready), 32'h0);
    check("t1_resp_valid", 32'(resp_valid), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);
    check("t1_resp_s", 32'(resp_s), 32'h0);
    check("t1_state", 32'(dbg_state), 32'h0);

    // T2: single request from requester 2, 12*13
    rst = 1'b0;
    resp_ready = 1'b1;
    req_valid = 4'b0100;
    set_ops(2, 8'd12, 8'd13);
    #1;
    check("t2_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'b0000;
    check("t2_calc_valid", 32'(resp_valid), 32'h0);
    check("t2_calc_busy", 32'(busy), 32'h1);
    check("t2_calc_s", 32'(resp_s), 32'h0);
    step();
    check("t2_resp_valid", 32'(resp_valid), 32'h1);
    check("t2_resp_s", 32'(resp_s), 32'd156);
    check("t2_resp_id", 32'(resp_id), 32'd2);
    step();
    check("t2_back_idle", 32'(busy), 32'h0);

    // T3: all requesters hold valid after a fresh reset; grants rotate 0,1,2,3,...
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    set_ops(0, 8'd3, 8'd7);
    set_ops(1, 8'd4, 8'd17);
    set_ops(2, 8'd5, 8'd27);
    set_ops(3, 8'd6, 8'd37);
    req_valid = 4'b1111;
    #1;
    for (int t = 0; t < 8; t++) begin
      int g;
      g = t % NREQ;
      case (g)
        0: exp_q.push_back(16'd21);
        1: exp_q.push_back(16'd68);
        2: exp_q.push_back(16'd135);
        default: exp_q.push_back(16'd222);
      endcase
      check("t3_ready", 32'(req_ready), 32'(1) << g);
      step();
      check("t3_calc_ready", 32'(req_ready), 32'h0);
      step();
      exp_s = exp_q.pop_front();
      check("t3_resp_valid", 32'(resp_valid), 32'h1);
      check("t3_resp_id", 32'(resp_id), 32'(g));
      check("t3_resp_s", 32'(resp_s), 32'(exp_s));
      step();
    end
    check("t3_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef MULT_SCHED_STATS_EN
    for (int i = 0; i < NREQ; i++) check("t3_grant_cnt", 32'(grant_cnt[i*16 +: 16]), 32'd2);
`endif
    req_valid = 4'b0000;

    // T4: 255*255 from requester 1 (pointer now at 3)
    set_ops(1, 8'd255, 8'd255);
    req_valid = 4'b0010;
    #1;
    check("t4_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b0000;
    step();
    check("t4_resp_s", 32'(resp_s), 32'hFE01);
    check("t4_resp_id", 32'(resp_id), 32'd1);
    step();

    // T5: consumer back-pressure for 5 cycles while RESP holds 100*200
    resp_ready = 1'b0;
    set_ops(3, 8'd100, 8'd200);
    req_valid = 4'b1000;
    #1;
    check("t5_ready", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b0001;
    #1;
    check("t5_calc_ready", 32'(req_ready), 32'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      check("t5_hold_valid", 32'(resp_valid), 32'h1);
      check("t5_hold_s", 32'(resp_s), 32'd20000);
      check("t5_hold_id", 32'(resp_id), 32'd3);
      check("t5_hold_ready", 32'(req_ready), 32'h0);
      step();
    end
    check("t5_still_resp", 32'(resp_valid), 32'h1);
    resp_ready = 1'b1;
    req_valid = 4'b0100;
    set_ops(2, 8'd9, 8'd9);
    step();
    check("t5_idle_busy", 32'(busy), 32'h0);
    check("t5_idle_valid", 32'(resp_valid), 32'h0);
    check("t5_next_ready", 32'(req_ready), 32'h4);

    // T6: reset during CALC drops the transaction and restarts the pointer
    step();
    check("t6_calc_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    req_valid = 4'b0000;
    step();
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_valid", 32'(resp_valid), 32'h0);
    check("t6_rst_s", 32'(resp_s), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t6_no_resp", 32'(resp_valid), 32'h0);
    end
    req_valid = 4'b1111;
    #1;
    check("t6_first_grant", 32'(req_ready), 32'h1);
`ifdef MULT_SCHED_STATS_EN
    for (int i = 0; i < NREQ; i++) check("t6_grant_cnt_clr", 32'(grant_cnt[i*16 +: 16]), 32'd0);
`endif
    req_valid = 4'b0000;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
